// File: rtl/keypad_scanner.sv
// keypad_scanner
// ----------------------------------------------------------------------------
// Scans a 4x4 matrix keypad. It drives one column at a time and samples the
// row lines once per column dwell. It then debounces the press and its
// release, and reports the accepted key as a one-hot {row, column} code.
//
// Parameters:
//   SCAN_DIV  clock cycles each column is driven (>= 2)
//   DEBOUNCE  consecutive matching samples needed to accept a press/release (>= 1)
//
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous, active-high
//   rows      raw keypad row lines (asynchronous, synchronized internally)
//   cols      one-hot column drive
//   rowCol    {row[3:0], col[3:0]} of the last accepted key, 8'h00 after reset
//   keyValid  one-cycle pulse when a press is accepted
//   keyHeld   high from press acceptance until release acceptance
//
// Build option:
//   KEYPAD_ACTIVE_LOW_EN  when defined, the keypad uses pull-ups. The column
//                         pins are driven inverted (e.g. 4'b1110) and the row
//                         pins are inverted before the synchronizer. rowCol
//                         stays active-high in both builds.
// ----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] rowCol,
  output logic       keyValid,
  output logic       keyHeld
);

  localparam int DC_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               INSTANT = (DEBOUNCE == 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // Row lines in active-high form, ahead of the synchronizer.
  logic [3:0] rows_in;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       rs_q, rs_d;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       cand_row_q, cand_row_d;
  logic [3:0]       cand_col_q, cand_col_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [7:0]       row_col_q, row_col_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             sample;
  logic [3:0]       rs_red;
  logic [3:0]       col_next;

`ifdef KEYPAD_ACTIVE_LOW_EN
  assign rows_in = ~rows;
  assign cols    = ~col_q;
`else
  assign rows_in = rows;
  assign cols    = col_q;
`endif

  assign rowCol   = row_col_q;
  assign keyValid = key_valid_q;
  assign keyHeld  = key_held_q;

  assign sample   = (dc_q == DC_LAST);
  // Lowest set bit wins when several rows are active at once.
  assign rs_red   = rs_q & (~rs_q + 4'd1);
  assign col_next = {col_q[2:0], col_q[3]};

  always_comb begin
    state_d     = state_q;
    sync1_d     = rows_in;
    rs_d        = sync1_q;
    dc_d        = (dc_q == DC_LAST) ? '0 : dc_q + 1'b1;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    match_d     = match_q;
    rel_d       = rel_q;
    row_col_d   = row_col_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (sample) begin
      unique case (state_q)
        ST_SCAN: begin
          if (rs_q != 4'd0) begin
            // The column stays frozen from here until the key is rejected or released.
            cand_row_d = rs_red;
            cand_col_d = col_q;
            match_d    = CNT_ONE;
            if (INSTANT) begin
              state_d     = ST_HELD;
              row_col_d   = {rs_red, col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_d       = '0;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_next;
          end
        end

        ST_DEBOUNCE: begin
          if (rs_red == cand_row_q) begin
            if (match_q + CNT_ONE == DEB_CNT) begin
              state_d     = ST_HELD;
              row_col_d   = {cand_row_q, cand_col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_d       = '0;
            end else begin
              match_d = match_q + CNT_ONE;
            end
          end else begin
            state_d = ST_SCAN;
            col_d   = col_next;
          end
        end

        ST_HELD: begin
          // Any activity on the frozen column restarts the release count.
          if (rs_q == 4'd0) begin
            if (rel_q + CNT_ONE == DEB_CNT) begin
              state_d    = ST_SCAN;
              key_held_d = 1'b0;
              col_d      = col_next;
              rel_d      = '0;
            end else begin
              rel_d = rel_q + CNT_ONE;
            end
          end else begin
            rel_d = '0;
          end
        end

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      sync1_q     <= 4'd0;
      rs_q        <= 4'd0;
      dc_q        <= '0;
      col_q       <= 4'b0001;
      cand_row_q  <= 4'd0;
      cand_col_q  <= 4'd0;
      match_q     <= '0;
      rel_q       <= '0;
      row_col_q   <= 8'h00;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rs_q        <= rs_d;
      dc_q        <= dc_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      match_q     <= match_d;
      rel_q       <= rel_d;
      row_col_q   <= row_col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a behavioural keypad, a reference model
// stepped once per clock, a per-cycle output compare and directed literal checks.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
`ifdef KEYPAD_ACTIVE_LOW_EN
  localparam bit ACTIVE_LOW = 1'b1;
`else
  localparam bit ACTIVE_LOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] rowCol;
  logic       keyValid;
  logic       keyHeld;

  // Keypad: one key (possibly several rows in the same column) is pressed.
  // The key's rows are connected only while its column is driven.
  bit         key_on = 1'b0;
  logic [1:0] key_col = 2'd0;
  logic [3:0] key_rows = 4'd0;
  logic [3:0] cols_log;
  logic [3:0] rows_log;

  assign cols_log = ACTIVE_LOW ? ~cols : cols;
  assign rows_log = (key_on && cols_log[key_col]) ? key_rows : 4'd0;
  assign rows     = ACTIVE_LOW ? ~rows_log : rows_log;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .rowCol(rowCol),
    .keyValid(keyValid),
    .keyHeld(keyHeld)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 scanning, 1 confirming a candidate, 2 key held
  logic [3:0] m_s1 = 4'd0, m_rs = 4'd0, m_cand_row = 4'd0;
  int         m_ph = 0, m_col = 0, m_mode = 0, m_cand_col = 0, m_match = 0, m_rel = 0;
  logic [7:0] m_rowcol = 8'h00;
  bit         m_valid = 1'b0, m_held = 1'b0;

  function automatic logic [3:0] lowest(input logic [3:0] v);
    logic [3:0] r;
    bit found;
    r = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        r = 4'd1 << i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_accept();
    m_mode   = 2;
    m_rowcol = {m_cand_row, 4'(1 << m_cand_col)};
    m_valid  = 1'b1;
    m_held   = 1'b1;
    m_rel    = 0;
  endtask

  task automatic model_step();
    logic [3:0] raw;
    logic [3:0] red;
    raw = ACTIVE_LOW ? ~rows : rows;
    if (reset) begin
      m_s1 = 4'd0; m_rs = 4'd0; m_ph = 0; m_col = 0; m_mode = 0;
      m_match = 0; m_rel = 0; m_rowcol = 8'h00; m_valid = 1'b0; m_held = 1'b0;
      m_cand_row = 4'd0; m_cand_col = 0;
    end else begin
      red = lowest(m_rs);
      m_valid = 1'b0;
      if (m_ph == SCAN_DIV - 1) begin
        if (m_mode == 0) begin
          if (m_rs != 4'd0) begin
            m_cand_row = red;
            m_cand_col = m_col;
            m_match = 1;
            if (m_match >= DEBOUNCE) model_accept();
            else m_mode = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else if (m_mode == 1) begin
          if (red == m_cand_row) begin
            m_match++;
            if (m_match >= DEBOUNCE) model_accept();
          end else begin
            m_mode = 0;
            m_col = (m_col + 1) % 4;
          end
        end else begin
          if (m_rs == 4'd0) begin
            m_rel++;
            if (m_rel >= DEBOUNCE) begin
              m_mode = 0;
              m_held = 1'b0;
              m_rel = 0;
              m_col = (m_col + 1) % 4;
            end
          end else begin
            m_rel = 0;
          end
        end
      end
      m_rs = m_s1;
      m_s1 = raw;
      m_ph = (m_ph + 1) % SCAN_DIV;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [3:0] exp_log;
    logic [3:0] exp_pin;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_log = 4'(1 << m_col);
        exp_pin = ACTIVE_LOW ? ~exp_log : exp_log;
        checks++;
        if (cols !== exp_pin || rowCol !== m_rowcol || keyValid !== m_valid || keyHeld !== m_held) begin
          failures++;
          $display("FAIL cycle_cmp t=%0t cols act=%b exp=%b rowCol act=%h exp=%h keyValid act=%b exp=%b keyHeld act=%b exp=%b",
                   $time, cols, exp_pin, rowCol, m_rowcol, keyValid, m_valid, keyHeld, m_held);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic pin(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end else begin
      $display("check %s ok value=%0h", name, act);
    end
  endtask

  task automatic wait_valid(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (keyValid) got = 1'b1;
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (keyValid) cnt++;
    end
  endtask

  task automatic wait_release(input int limit, output int n);
    n = 0;
    while (keyHeld && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    int cnt;
    int n;
    bit seen;

    // Reset and idle scan.
    reset = 1'b1;
    key_on = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    pin("reset_cols", int'(cols_log), 32'h1);
    pin("reset_rowCol", int'(rowCol), 32'h0);
    pin("reset_keyValid", int'(keyValid), 0);
    pin("reset_keyHeld", int'(keyHeld), 0);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (keyValid) cnt++;
      if (k % 4 == 0 && k <= 16) pin($sformatf("idle_cols_k%0d", k), int'(cols_log), 1 << ((k / 4) % 4));
    end
    pin("idle_no_valid", cnt, 0);

    // Press row 1, column 2 and hold it.
    key_col = 2'd2;
    key_rows = 4'b0010;
    key_on = 1'b1;
    wait_valid(80, got);
    pin("press_valid_seen", int'(got), 1);
    pin("press_rowCol", int'(rowCol), 32'h24);
    pin("press_keyHeld", int'(keyHeld), 1);
    count_valid(30, cnt);
    pin("press_single_pulse", cnt, 0);
    pin("held_cols_pin", int'(cols), ACTIVE_LOW ? 32'hB : 32'h4);
    pin("held_keyHeld", int'(keyHeld), 1);

    // Clean release.
    key_on = 1'b0;
    wait_release(40, n);
    pin("release_latency_in_range", int'(n >= 11 && n <= 14), 1);
    pin("release_cols", int'(cols_log), 32'h8);
    pin("release_rowCol_kept", int'(rowCol), 32'h24);

    // Bounce: one matching sample, then a mismatch.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cols_log == 4'b0100) seen = 1'b1;
    end
    pin("bounce_col2_reached", int'(seen), 1);
    key_col = 2'd2;
    key_rows = 4'b0010;
    key_on = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (keyValid) cnt++;
    end
    key_on = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (keyValid) cnt++;
    end
    pin("bounce_cols_advanced", int'(cols_log), 32'h8);
    pin("bounce_keyHeld", int'(keyHeld), 0);
    count_valid(12, n);
    pin("bounce_no_valid", cnt + n, 0);

    // Two rows in column 0, then a release interrupted by a glitch.
    key_col = 2'd0;
    key_rows = 4'b0110;
    key_on = 1'b1;
    wait_valid(80, got);
    pin("multi_valid_seen", int'(got), 1);
    pin("multi_rowCol", int'(rowCol), 32'h21);
    repeat (5) @(negedge clk);
    key_on = 1'b0;
    repeat (6) @(negedge clk);
    key_on = 1'b1;
    repeat (4) @(negedge clk);
    key_on = 1'b0;
    pin("glitch_still_held", int'(keyHeld), 1);
    wait_release(60, n);
    pin("glitch_released", int'(keyHeld), 0);
    pin("glitch_rowCol_kept", int'(rowCol), 32'h21);

    // Reset while the key is held.
    key_col = 2'd2;
    key_rows = 4'b0010;
    key_on = 1'b1;
    wait_valid(80, got);
    pin("rst_press_seen", int'(got), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key_on = 1'b0;
    pin("rst_cols", int'(cols_log), 32'h1);
    pin("rst_rowCol", int'(rowCol), 32'h0);
    pin("rst_keyHeld", int'(keyHeld), 0);
    pin("rst_keyValid", int'(keyValid), 0);

    // Randomized presses, releases and occasional resets.
    for (int it = 0; it < 150; it++) begin
      key_col = 2'($urandom_range(0, 3));
      key_rows = 4'($urandom_range(1, 15));
      key_on = 1'b1;
      repeat ($urandom_range(1, 50)) @(negedge clk);
      key_on = 1'b0;
      repeat ($urandom_range(1, 50)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
